// File: rtl/morse_pkg.sv
// Shared Morse timing definitions for the encoder and decoder paths:
// FSM states, element limits and default unit multiples.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_MARK       = 2'd1,
        ST_GAP        = 2'd2,
        ST_LETTER_GAP = 2'd3
    } morse_state_e;

    localparam int MAX_ELEMENTS         = 5;
    localparam int DOT_UNITS            = 1;
    localparam int DEF_DASH_UNITS       = 3;
    localparam int DEF_LETTER_GAP_UNITS = 3;
    localparam int UNIT_CNT_W           = 2;

    function automatic logic length_ok(input logic [2:0] len);
        return (len >= 3'd1) && (len <= 3'(MAX_ELEMENTS));
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Mod-UNIT_TICKS counter; unit_tick is a registered one-cycle pulse in the
// last tick of every unit, and clr restarts the unit from tick zero.
module morse_unit_timer #(
    parameter int UNIT_TICKS = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic unit_tick
);
    localparam int W = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
    localparam logic [W-1:0] TICK_LAST = W'(UNIT_TICKS - 1);
    localparam logic [W-1:0] TICK_PRE  = W'(UNIT_TICKS - 2);

    logic [W-1:0] tick_cnt_r;
    logic         unit_tick_r;

    // Tick counter; the pulse is registered one count early so it lines up with TICK_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r  <= {W{1'b0}};
            unit_tick_r <= 1'b0;
        end else if (clr) begin
            tick_cnt_r  <= {W{1'b0}};
            unit_tick_r <= 1'b0;
        end else begin
            if (tick_cnt_r == TICK_LAST) begin
                tick_cnt_r <= {W{1'b0}};
            end else begin
                tick_cnt_r <= tick_cnt_r + W'(1);
            end
            unit_tick_r <= (tick_cnt_r == TICK_PRE);
        end
    end

    assign unit_tick = unit_tick_r;

endmodule

// File: rtl/morse_encoder.sv
// Keys one Morse letter (pattern MSB-first over length elements) onto tx,
// with dot/dash marks, inter-element gaps and a trailing letter gap.
module morse_encoder import morse_pkg::*; #(
    parameter int UNIT_TICKS       = 10_000_000,
    parameter int DASH_UNITS       = DEF_DASH_UNITS,
    parameter int LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] length,
    input  logic [4:0] pattern,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam logic [UNIT_CNT_W-1:0] DOT_LAST  = UNIT_CNT_W'(DOT_UNITS - 1);
    localparam logic [UNIT_CNT_W-1:0] DASH_LAST = UNIT_CNT_W'(DASH_UNITS - 1);
    localparam logic [UNIT_CNT_W-1:0] LG_LAST   = UNIT_CNT_W'(LETTER_GAP_UNITS - 1);

    morse_state_e              state_r, state_next_s;
    logic                      tx_r, busy_r, done_r;
    logic                      tx_next_s, busy_next_s, done_next_s;
    logic [4:0]                pat_r;
    logic [2:0]                index_r;
    logic [UNIT_CNT_W-1:0]     unit_cnt_r;
    logic [UNIT_CNT_W-1:0]     units_last_s;
    logic                      unit_tick_s;
    logic                      period_end_s;
    logic                      accept_s;
    logic                      timer_clr_s;

    assign accept_s     = (state_r == ST_IDLE) && start && length_ok(length);
    assign period_end_s = unit_tick_s && (unit_cnt_r == units_last_s);
    // Every state change restarts both counters so each period is exact.
    assign timer_clr_s  = (state_r == ST_IDLE) || (state_next_s != state_r);

    morse_unit_timer #(
        .UNIT_TICKS (UNIT_TICKS)
    ) u_timer (
        .clk       (clk),
        .rst_n     (reset_n),
        .clr       (timer_clr_s),
        .unit_tick (unit_tick_s)
    );

    // Length of the current period in units, minus one.
    always_comb begin
        units_last_s = DOT_LAST;
        case (state_r)
            ST_MARK:       units_last_s = pat_r[index_r] ? DASH_LAST : DOT_LAST;
            ST_GAP:        units_last_s = DOT_LAST;
            ST_LETTER_GAP: units_last_s = LG_LAST;
            default:       units_last_s = DOT_LAST;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_MARK;
                else          state_next_s = ST_IDLE;
            end
            ST_MARK: begin
                if (period_end_s) state_next_s = (index_r == 3'd0) ? ST_LETTER_GAP : ST_GAP;
                else              state_next_s = ST_MARK;
            end
            ST_GAP: begin
                if (period_end_s) state_next_s = ST_MARK;
                else              state_next_s = ST_GAP;
            end
            ST_LETTER_GAP: begin
                if (period_end_s) state_next_s = ST_IDLE;
                else              state_next_s = ST_LETTER_GAP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state.
    always_comb begin
        tx_next_s   = (state_next_s == ST_MARK);
        busy_next_s = (state_next_s != ST_IDLE);
        done_next_s = (state_r == ST_LETTER_GAP) && (state_next_s == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            tx_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            tx_r    <= tx_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Latched letter, element index and unit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_r      <= 5'd0;
            index_r    <= 3'd0;
            unit_cnt_r <= {UNIT_CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                pat_r   <= pattern;
                index_r <= length - 3'd1;
            end else if ((state_r == ST_MARK) && period_end_s && (index_r != 3'd0)) begin
                index_r <= index_r - 3'd1;
            end
            if (timer_clr_s) begin
                unit_cnt_r <= {UNIT_CNT_W{1'b0}};
            end else if (unit_tick_s) begin
                unit_cnt_r <= unit_cnt_r + UNIT_CNT_W'(1);
            end
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: a queue of expected tx levels is built per letter
// and compared against tx/busy/done every cycle, plus literal timing checks.
module tb_morse_encoder;
    localparam int U  = 4;
    localparam int DU = 3;
    localparam int LU = 3;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [2:0] length;
    logic [4:0] pattern;
    logic       tx, busy, done;

    int  checks   = 0;
    int  failures = 0;
    int  mq[$];
    bit  m_done;
    int  done_cnt = 0;
    int  run = 0, txr = 0, last_run = 0, last_tx = 0;

    morse_encoder #(.UNIT_TICKS(U)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .length  (length),
        .pattern (pattern),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected tx level for every cycle of the letter, first element from the top used bit.
    task automatic load(input logic [2:0] len, input logic [4:0] pat);
        int u;
        for (int i = int'(len) - 1; i >= 0; i--) begin
            u = pat[i] ? DU : 1;
            repeat (u * U) mq.push_back(1);
            if (i != 0) repeat (U) mq.push_back(0);
        end
        repeat (LU * U) mq.push_back(0);
    endtask

    // One clock: sample inputs, advance the model at posedge, compare at negedge.
    task automatic step();
        logic       s_start, s_rst;
        logic [2:0] s_len;
        logic [4:0] s_pat;
        s_start = start; s_len = length; s_pat = pattern; s_rst = reset_n;
        @(posedge clk);
        m_done = 1'b0;
        if (!s_rst) begin
            mq.delete();
        end else if (mq.size() > 0) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_done = 1'b1;
        end else if (s_start && s_len >= 3'd1 && s_len <= 3'd5) begin
            load(s_len, s_pat);
        end
        @(negedge clk);
        if (!reset_n) begin
            mq.delete();
            m_done = 1'b0;
        end
        chk("tx",   int'(tx),   (mq.size() > 0) ? mq[0] : 0);
        chk("busy", int'(busy), (mq.size() > 0) ? 1 : 0);
        chk("done", int'(done), int'(m_done));
        if (done) done_cnt++;
        if (!reset_n) begin
            run = 0; txr = 0;
        end else if (busy) begin
            run++;
            if (tx) txr++;
        end else if (run > 0) begin
            last_run = run; last_tx = txr; run = 0; txr = 0;
        end
    endtask

    task automatic send(input logic [2:0] len, input logic [4:0] pat);
        start = 1'b1; length = len; pattern = pat;
        step();
        start = 1'b0; length = $urandom_range(0, 7); pattern = 5'($urandom);
    endtask

    task automatic wait_done(input int maxc, input bit noise);
        int dc0 = done_cnt;
        for (int n = 0; n < maxc; n++) begin
            if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                length = $urandom_range(1, 5);
            end
            step();
            if (done_cnt != dc0) break;
        end
        start = 1'b0;
        chk("done_timeout", (done_cnt != dc0) ? 1 : 0, 1);
    endtask

    initial begin
        int dc;
        reset_n = 1'b0; start = 1'b0; length = 3'd0; pattern = 5'd0;
        repeat (3) step();
        chk("reset_tx", int'(tx), 0);
        chk("reset_busy", int'(busy), 0);
        reset_n = 1'b1;
        repeat (2) step();

        // 'E'
        dc = done_cnt;
        send(3'd1, 5'b00000);
        wait_done(200, 1'b0);
        chk("E_busy_len", last_run, 16);
        chk("E_tx_len", last_tx, 4);
        chk("E_dones", done_cnt - dc, 1);

        // 'A' with start pulses during busy
        dc = done_cnt;
        send(3'd2, 5'b00001);
        wait_done(200, 1'b1);
        chk("A_busy_len", last_run, 32);
        chk("A_tx_len", last_tx, 16);
        chk("A_dones", done_cnt - dc, 1);

        // Invalid lengths while idle
        dc = done_cnt;
        send(3'd0, 5'b10101);
        send(3'd6, 5'b11111);
        send(3'd7, 5'b00000);
        repeat (3) step();
        chk("invalid_busy", int'(busy), 0);
        chk("invalid_dones", done_cnt - dc, 0);

        // Back-to-back: 'E' requested in the done cycle of 'A'
        send(3'd2, 5'b00001);
        wait_done(200, 1'b0);
        chk("b2b_done_now", int'(done), 1);
        send(3'd1, 5'b00000);
        chk("b2b_tx", int'(tx), 1);
        chk("b2b_busy", int'(busy), 1);
        wait_done(200, 1'b0);
        chk("b2b_E_len", last_run, 16);

        // '0'
        send(3'd5, 5'b11111);
        wait_done(200, 1'b0);
        chk("zero_busy_len", last_run, 88);
        chk("zero_tx_len", last_tx, 60);

        // Reset in the middle of the first dash of '0'
        send(3'd5, 5'b11111);
        repeat (5) step();
        chk("pre_reset_tx", int'(tx), 1);
        reset_n = 1'b0;
        #1;
        chk("async_tx", int'(tx), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (4) step();
        chk("post_reset_idle", int'(busy), 0);
        send(3'd1, 5'b00000);
        wait_done(200, 1'b0);
        chk("post_reset_E_len", last_run, 16);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            start   = ($urandom_range(0, 5) == 0);
            length  = $urandom_range(0, 7);
            pattern = 5'($urandom);
            step();
        end
        start = 1'b0;
        repeat (100) step();
        chk("final_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
